// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory with wait states and address error flagging
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic acc, acc_wr, acc_err, we;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-3:0] acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  // Access operands: live request inputs on a zero-wait accept, latched copies otherwise
  always_comb begin
    acc_wr    = state_q == IDLE ? req_write : wr_q;
    acc_addr  = state_q == IDLE ? req_addr : addr_q;
    acc_wdata = state_q == IDLE ? req_wdata : wdata_q;
    acc_idx   = acc_addr[ADDR_W-1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || (int'(acc_idx) >= DEPTH);
    we        = acc && acc_wr && !acc_err;
  end
  // Next-state, wait counter, request latch and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc     = 1'b0;
    if (state_q == IDLE && req_valid) begin
      wr_d    = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = WC;
      acc     = WC == 4'd0;
      state_d = acc ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      acc     = cnt_q == 4'd1;
      state_d = acc ? RESP : WAIT;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
    if (acc) begin
      rdata_d = (!acc_wr && !acc_err) ? mem_q[acc_idx] : '0;
      err_d   = acc_err;
    end
  end
  // Control and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Storage array: cleared on reset, written once on the access edge of an error-free store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with 2-wait and 0-wait builds
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b1;
  logic [7:0] z_req_addr = '0;
  logic [31:0] z_req_wdata = '0;
  logic z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;
  logic [31:0] mdl [64];
  logic [32:0] sb [$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [7:0] a, input logic [31:0] d, input int hold);
    logic er;
    logic [32:0] e, got;
    int n;
    er = a[1:0] != 2'b00;
    sb.push_back({er, (w || er) ? 32'h0 : mdl[a[7:2]]});
    if (w && !er) mdl[a[7:2]] = d;
    check("req_ready", 32'(req_ready), 32'd1);
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_ready = hold == 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = 8'($urandom);
    req_wdata = $urandom;
    req_write = ~w;
    check("busy_wait", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 32'd2);
    got = {rsp_err, rsp_rdata};
    e = sb.pop_front();
    check("rdata", got[31:0], e[31:0]);
    check("err", 32'(got[32]), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr = 8'h08;
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, got[31:0]);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    xact(1'b0, 8'h10, 32'h0, 0);
    xact(1'b1, 8'h08, 32'hDEADBEEF, 0);
    xact(1'b0, 8'h08, 32'h0, 0);
    xact(1'b1, 8'h0A, 32'h12345678, 0);
    xact(1'b0, 8'h08, 32'h0, 0);
    xact(1'b0, 8'h08, 32'h0, 5);
    xact(1'b0, 8'h03, 32'h0, 0);
    xact(1'b1, 8'hFC, 32'hA5A5_0001, 0);
    xact(1'b0, 8'hFC, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      a = {6'($urandom_range(0, 63)), 2'b00};
      xact(1'b1, a, $urandom, 0);
      xact(1'b0, a, 32'h0, 0);
    end
    req_write = 1'b1;
    req_addr = 8'h20;
    req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    check("rw_busy_after", 32'(busy), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd1);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    xact(1'b0, 8'h20, 32'h0, 0);
    xact(1'b0, 8'h08, 32'h0, 0);
    z_req_write = 1'b1;
    z_req_addr = 8'hFC;
    z_req_wdata = 32'h00000001;
    z_req_valid = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    z_req_wdata = 32'hFFFF_FFFF;
    check("z_st_valid", 32'(z_rsp_valid), 32'd1);
    check("z_st_err", 32'(z_rsp_err), 32'd0);
    check("z_st_rdata", z_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("z_ready", 32'(z_req_ready), 32'd1);
    z_req_write = 1'b0;
    z_req_valid = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("z_ld_valid", 32'(z_rsp_valid), 32'd1);
    check("z_ld_rdata", z_rsp_rdata, 32'h00000001);
    check("z_ld_err", 32'(z_rsp_err), 32'd0);
    @(posedge clk); #1;
    z_req_addr = 8'hFD;
    z_req_valid = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("z_mis_err", 32'(z_rsp_err), 32'd1);
    check("z_mis_rdata", z_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("z_idle", 32'(z_busy), 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
